// File: rtl/nonce_sweep_ctrl.sv
// Nonce sweep controller: walks a nonce range through a SHA-256 accelerator,
// compares each final digest to the job target and reports hit/exhausted/abort/timeout.
module nonce_sweep_ctrl #(
    parameter int unsigned NONCE_W     = 32,
    parameter int unsigned DIGEST_W    = 256,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                job_valid,
    output logic                job_ready,
    input  logic [NONCE_W-1:0]  job_first,
    input  logic [NONCE_W-1:0]  job_last,
    input  logic [DIGEST_W-1:0] job_target,
    input  logic                abort,
    output logic                hash_start,
    input  logic                hash_done,
    input  logic                save_hash,
    input  logic [1:0]          msg_sel,
    input  logic [DIGEST_W-1:0] digest,
    output logic [NONCE_W-1:0]  nonce,
    output logic                busy,
    output logic                res_valid,
    input  logic                res_ready,
    output logic                res_found,
    output logic                res_abort,
    output logic                res_tmo,
    output logic [NONCE_W-1:0]  res_nonce,
    output logic [DIGEST_W-1:0] res_digest
);

    localparam int unsigned WD_W = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_CHECK,
        S_RESP
    } state_t;

    state_t              state_q, state_d;
    logic [NONCE_W-1:0]  nonce_q, nonce_d;
    logic [NONCE_W-1:0]  last_q, last_d;
    logic [DIGEST_W-1:0] target_q, target_d;
    logic [WD_W-1:0]     wdog_q, wdog_d;
    logic                first_wait_q, first_wait_d;
    logic                abort_flag_q, abort_flag_d;
    logic                job_ready_q, job_ready_d;
    logic                hash_start_q, hash_start_d;
    logic                busy_q, busy_d;
    logic                res_valid_q, res_valid_d;
    logic                res_found_q, res_found_d;
    logic                res_abort_q, res_abort_d;
    logic                res_tmo_q, res_tmo_d;
    logic [NONCE_W-1:0]  res_nonce_q, res_nonce_d;
    logic [DIGEST_W-1:0] res_digest_q, res_digest_d;
    logic                hit_c;

    assign job_ready  = job_ready_q;
    assign hash_start = hash_start_q;
    assign nonce      = nonce_q;
    assign busy       = busy_q;
    assign res_valid  = res_valid_q;
    assign res_found  = res_found_q;
    assign res_abort  = res_abort_q;
    assign res_tmo    = res_tmo_q;
    assign res_nonce  = res_nonce_q;
    assign res_digest = res_digest_q;

    assign hit_c = (res_digest_q <= target_q);

    // Next-state and next-output logic; registered outputs follow state_d.
    always_comb begin
        state_d      = state_q;
        nonce_d      = nonce_q;
        last_d       = last_q;
        target_d     = target_q;
        wdog_d       = wdog_q;
        first_wait_d = first_wait_q;
        abort_flag_d = abort_flag_q;
        res_found_d  = res_found_q;
        res_abort_d  = res_abort_q;
        res_tmo_d    = res_tmo_q;
        res_nonce_d  = res_nonce_q;
        res_digest_d = res_digest_q;

        // Abort is sticky while hashing; the in-flight hash still completes.
        if (abort && (state_q == S_START || state_q == S_WAIT || state_q == S_CHECK)) begin
            abort_flag_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (job_valid && job_ready_q) begin
                    nonce_d      = job_first;
                    last_d       = job_last;
                    target_d     = job_target;
                    abort_flag_d = 1'b0;
                    state_d      = S_START;
                end
            end
            S_START: begin
                wdog_d       = '0;
                first_wait_d = 1'b1;
                state_d      = S_WAIT;
            end
            S_WAIT: begin
                first_wait_d = 1'b0;
                wdog_d       = wdog_q + WD_W'(1);
                if (save_hash && msg_sel == 2'd2) begin
                    res_digest_d = digest;
                end
                // hash_done may still be high from the previous hash on the first cycle.
                if (hash_done && !first_wait_q) begin
                    state_d = S_CHECK;
                end else if (wdog_d == WD_W'(TIMEOUT_CYC)) begin
                    res_tmo_d   = 1'b1;
                    res_nonce_d = nonce_q;
                    state_d     = S_RESP;
                end
            end
            S_CHECK: begin
                if (hit_c) begin
                    res_found_d = 1'b1;
                    res_nonce_d = nonce_q;
                    state_d     = S_RESP;
                end else if (abort_flag_q || abort) begin
                    res_abort_d = 1'b1;
                    res_nonce_d = nonce_q;
                    state_d     = S_RESP;
                end else if (nonce_q == last_q) begin
                    res_nonce_d = nonce_q;
                    state_d     = S_RESP;
                end else begin
                    nonce_d = nonce_q + NONCE_W'(1);
                    state_d = S_START;
                end
            end
            S_RESP: begin
                if (res_valid_q && res_ready) begin
                    res_found_d = 1'b0;
                    res_abort_d = 1'b0;
                    res_tmo_d   = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        job_ready_d  = (state_d == S_IDLE);
        busy_d       = (state_d != S_IDLE);
        hash_start_d = (state_d == S_START);
        res_valid_d  = (state_d == S_RESP);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            nonce_q      <= '0;
            last_q       <= '0;
            target_q     <= '0;
            wdog_q       <= '0;
            first_wait_q <= 1'b0;
            abort_flag_q <= 1'b0;
            job_ready_q  <= 1'b1;
            hash_start_q <= 1'b0;
            busy_q       <= 1'b0;
            res_valid_q  <= 1'b0;
            res_found_q  <= 1'b0;
            res_abort_q  <= 1'b0;
            res_tmo_q    <= 1'b0;
            res_nonce_q  <= '0;
            res_digest_q <= '0;
        end else begin
            state_q      <= state_d;
            nonce_q      <= nonce_d;
            last_q       <= last_d;
            target_q     <= target_d;
            wdog_q       <= wdog_d;
            first_wait_q <= first_wait_d;
            abort_flag_q <= abort_flag_d;
            job_ready_q  <= job_ready_d;
            hash_start_q <= hash_start_d;
            busy_q       <= busy_d;
            res_valid_q  <= res_valid_d;
            res_found_q  <= res_found_d;
            res_abort_q  <= res_abort_d;
            res_tmo_q    <= res_tmo_d;
            res_nonce_q  <= res_nonce_d;
            res_digest_q <= res_digest_d;
        end
    end

endmodule

// File: tb/tb_nonce_sweep_ctrl.sv
// Bench for nonce_sweep_ctrl: job vectors against an accelerator model, with
// per-hash nonce and per-job result scoreboards.
module tb_nonce_sweep_ctrl;

    localparam int unsigned NW  = 32;
    localparam int unsigned DW  = 256;
    localparam int unsigned TMO = 64;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          job_valid = 1'b0;
    logic          job_ready;
    logic [NW-1:0] job_first = '0;
    logic [NW-1:0] job_last = '0;
    logic [DW-1:0] job_target = '0;
    logic          abort;
    logic          hash_start;
    logic          hash_done;
    logic          save_hash;
    logic [1:0]    msg_sel;
    logic [DW-1:0] digest;
    logic [NW-1:0] nonce;
    logic          busy;
    logic          res_valid;
    logic          res_ready = 1'b0;
    logic          res_found;
    logic          res_abort;
    logic          res_tmo;
    logic [NW-1:0] res_nonce;
    logic [DW-1:0] res_digest;

    nonce_sweep_ctrl #(.NONCE_W(NW), .DIGEST_W(DW), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .rst(rst),
        .job_valid(job_valid), .job_ready(job_ready),
        .job_first(job_first), .job_last(job_last), .job_target(job_target),
        .abort(abort),
        .hash_start(hash_start), .hash_done(hash_done), .save_hash(save_hash),
        .msg_sel(msg_sel), .digest(digest),
        .nonce(nonce), .busy(busy),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_found(res_found), .res_abort(res_abort), .res_tmo(res_tmo),
        .res_nonce(res_nonce), .res_digest(res_digest)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [NW-1:0] first;
        logic [NW-1:0] last;
        logic [DW-1:0] target;
        logic [DW-1:0] dig;
        bit            hit_en;
        logic [NW-1:0] hit_nonce;
        bit            abort_en;
        logic [NW-1:0] abort_nonce;
        bit            hang;
        int            hold;
        bit            exp_found;
        bit            exp_abort;
        bit            exp_tmo;
        logic [NW-1:0] exp_nonce;
        int            exp_starts;
    } vec_t;

    int errors = 0;
    int checks = 0;

    logic [NW-1:0] exp_nonce_q[$];
    vec_t          exp_res_q[$];

    // Accelerator model configuration, set per vector.
    logic [DW-1:0] m_dig = '0;
    bit            m_hit_en = 0;
    logic [NW-1:0] m_hit_nonce = '0;
    bit            m_abort_en = 0;
    logic [NW-1:0] m_abort_nonce = '0;
    bit            m_hang = 0;
    int            start_cyc = 0;

    task automatic chk(input bit ok, input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] model_digest(input logic [NW-1:0] n);
        return (m_hit_en && n == m_hit_nonce) ? '0 : m_dig;
    endfunction

    function automatic vec_t mk(input logic [NW-1:0] f, input logic [NW-1:0] l,
                                input logic [DW-1:0] t, input logic [DW-1:0] d,
                                input bit he, input logic [NW-1:0] hn,
                                input bit ae, input logic [NW-1:0] an,
                                input bit hg, input int hold,
                                input bit ef, input bit ea, input bit et,
                                input logic [NW-1:0] en, input int es);
        vec_t v;
        v.first = f; v.last = l; v.target = t; v.dig = d;
        v.hit_en = he; v.hit_nonce = hn; v.abort_en = ae; v.abort_nonce = an;
        v.hang = hg; v.hold = hold;
        v.exp_found = ef; v.exp_abort = ea; v.exp_tmo = et;
        v.exp_nonce = en; v.exp_starts = es;
        return v;
    endfunction

    // Accelerator: 6-cycle hash, intermediate stage strobes carry a decoy digest of 0.
    initial begin
        int cnt;
        int abort_cnt;
        logic [NW-1:0] cur_nonce;
        logic [NW-1:0] e;
        cnt = 0; abort_cnt = 0; cur_nonce = '0;
        hash_done = 1'b0; save_hash = 1'b0; msg_sel = 2'd0; digest = '0; abort = 1'b0;
        forever begin
            @(posedge clk); #1;
            save_hash = 1'b0;
            abort = 1'b0;
            if (rst) begin
                cnt = 0; abort_cnt = 0; hash_done = 1'b0;
            end else begin
                if (hash_start) begin
                    start_cyc = cyc;
                    cur_nonce = nonce;
                    cnt = 6;
                    if (exp_nonce_q.size() == 0) begin
                        chk(1'b0, "extra_hash_start", DW'(nonce), '0);
                    end else begin
                        e = exp_nonce_q.pop_front();
                        chk(nonce == e, "start_nonce", DW'(nonce), DW'(e));
                    end
                    if (m_abort_en && nonce == m_abort_nonce) abort_cnt = 3;
                end else if (cnt > 0) begin
                    cnt--;
                    if (cnt == 5) hash_done = 1'b0;
                    if (cnt == 4) begin save_hash = 1'b1; msg_sel = 2'd0; digest = '0; end
                    if (cnt == 2) begin save_hash = 1'b1; msg_sel = 2'd1; digest = '0; end
                    if (cnt == 0) begin
                        save_hash = 1'b1; msg_sel = 2'd2; digest = model_digest(cur_nonce);
                        chk(nonce == cur_nonce, "nonce_stable", DW'(nonce), DW'(cur_nonce));
                        if (!m_hang) hash_done = 1'b1;
                    end
                end
                if (abort_cnt > 0) begin
                    abort_cnt--;
                    if (abort_cnt == 0) abort = 1'b1;
                end
            end
        end
    end

    task automatic submit(input vec_t v);
        bit ok;
        m_dig = v.dig; m_hit_en = v.hit_en; m_hit_nonce = v.hit_nonce;
        m_abort_en = v.abort_en; m_abort_nonce = v.abort_nonce; m_hang = v.hang;
        for (int i = 0; i < v.exp_starts; i++) exp_nonce_q.push_back(v.first + NW'(i));
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (job_ready) begin ok = 1; break; end
        end
        chk(ok, "job_ready_wait", DW'(job_ready), DW'(1));
        job_first = v.first; job_last = v.last; job_target = v.target; job_valid = 1'b1;
        @(negedge clk);
        job_valid = 1'b0;
        chk(busy && !job_ready, "busy_after_accept", DW'({busy, job_ready}), DW'(2'b10));
    endtask

    task automatic run_vec(input vec_t v);
        bit ok;
        vec_t e;
        logic [DW-1:0] exp_dig;
        logic [5:0] exp_flags;
        submit(v);
        exp_res_q.push_back(v);
        ok = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (res_valid) begin ok = 1; break; end
        end
        e = exp_res_q.pop_front();
        chk(ok, "res_valid_wait", DW'(res_valid), DW'(1));
        if (!ok) begin
            exp_nonce_q.delete();
            return;
        end
        exp_dig = model_digest(e.exp_nonce);
        exp_flags = {e.exp_found, e.exp_abort, e.exp_tmo, 3'b100};
        chk({res_found, res_abort, res_tmo, busy, hash_start, job_ready} == exp_flags,
            "res_flags", DW'({res_found, res_abort, res_tmo, busy, hash_start, job_ready}), DW'(exp_flags));
        chk(res_nonce == e.exp_nonce, "res_nonce", DW'(res_nonce), DW'(e.exp_nonce));
        if (!e.exp_tmo) chk(res_digest == exp_dig, "res_digest", res_digest, exp_dig);
        else chk((cyc - start_cyc) >= TMO && (cyc - start_cyc) <= TMO + 2, "tmo_latency",
                 DW'(cyc - start_cyc), DW'(TMO + 1));
        chk(exp_nonce_q.size() == 0, "missing_starts", DW'(exp_nonce_q.size()), '0);
        for (int i = 0; i < e.hold; i++) begin
            @(negedge clk);
            chk(res_valid && {res_found, res_abort, res_tmo} == exp_flags[5:3] && res_nonce == e.exp_nonce
                && res_digest == exp_dig && !hash_start,
                "hold_stable", DW'({res_valid, res_found, res_abort, res_tmo, res_nonce}),
                DW'({1'b1, exp_flags[5:3], e.exp_nonce}));
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        chk(!res_valid && job_ready && !busy && !res_found && !res_abort && !res_tmo,
            "after_handshake", DW'({res_valid, job_ready, busy, res_found, res_abort, res_tmo}), DW'(6'b010000));
        exp_nonce_q.delete();
    endtask

    vec_t vecs[12];

    initial begin
        logic [DW-1:0] all1;
        logic [DW-1:0] mid;
        bit saw_valid;
        all1 = '1;
        mid  = {1'b1, {(DW-1){1'b0}}};

        vecs[0]  = mk(32'd5, 32'd7, all1, '0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 32'd5, 1);
        vecs[1]  = mk(32'd5, 32'd7, '0, DW'(1), 0, 0, 0, 0, 0, 20, 0, 0, 0, 32'd7, 3);
        vecs[2]  = mk(32'hFFFF_FFFE, 32'd1, '0, DW'(1), 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'd1, 4);
        vecs[3]  = mk(32'd8, 32'd20, '0, DW'(1), 0, 0, 1, 32'd10, 0, 0, 0, 1, 0, 32'd10, 3);
        vecs[4]  = mk(32'd8, 32'd20, '0, DW'(1), 1, 32'd10, 1, 32'd10, 0, 0, 1, 0, 0, 32'd10, 3);
        vecs[5]  = mk(32'd42, 32'd42, '0, DW'(1), 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'd42, 1);
        vecs[6]  = mk(32'd100, 32'd101, mid, mid, 0, 0, 0, 0, 0, 0, 1, 0, 0, 32'd100, 1);
        vecs[7]  = mk(32'd100, 32'd101, mid, mid + DW'(1), 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'd101, 2);
        vecs[8]  = mk(32'd0, 32'd3, mid, mid - DW'(1), 0, 0, 0, 0, 0, 0, 1, 0, 0, 32'd0, 1);
        vecs[9]  = mk(32'd3, 32'd9, '0, DW'(1), 0, 0, 0, 0, 1, 0, 0, 0, 1, 32'd3, 1);
        vecs[10] = mk(32'hFFFF_FFFF, 32'hFFFF_FFFF, '0, DW'(1), 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'hFFFF_FFFF, 1);
        vecs[11] = mk(32'd200, 32'd210, '0, DW'(1), 1, 32'd203, 0, 0, 0, 0, 1, 0, 0, 32'd203, 4);

        repeat (3) @(negedge clk);
        chk({job_ready, busy, hash_start, res_valid, res_found, res_abort, res_tmo} == 7'b1000000,
            "reset_ctrl", DW'({job_ready, busy, hash_start, res_valid, res_found, res_abort, res_tmo}), DW'(7'b1000000));
        chk(nonce == '0 && res_nonce == '0 && res_digest == '0, "reset_data",
            DW'({nonce, res_nonce}), '0);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) run_vec(vecs[i]);

        // Reset while the accelerator is mid-hash: job dropped, no result.
        submit(mk(32'd50, 32'd60, '0, DW'(1), 0, 0, 0, 0, 1, 0, 0, 0, 0, 32'd50, 1));
        repeat (6) @(negedge clk);
        chk(busy && !hash_start, "busy_in_wait", DW'({busy, hash_start}), DW'(2'b10));
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        saw_valid = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (res_valid || busy || hash_start || !job_ready) saw_valid = 1;
        end
        chk(!saw_valid, "idle_after_rst", DW'(saw_valid), '0);
        chk(nonce == '0 && res_nonce == '0 && res_digest == '0 && !res_found && !res_tmo,
            "data_after_rst", DW'({nonce, res_nonce}), '0);
        chk(exp_nonce_q.size() == 0, "rst_job_start", DW'(exp_nonce_q.size()), '0);
        exp_nonce_q.delete();

        run_vec(vecs[0]);
        run_vec(vecs[7]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got cycle %0d required finish", cyc);
        $fatal(1);
    end

endmodule
